// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   state_t   : responder FSM states (IDLE, WAIT, RESP)
//   WORD_W    : data word width in bits
//   BE_W      : byte-enable width
//   addr_ok() : 1 when a byte address is word-aligned and inside the array
// Optional build macro used by this slice: DMEM_BYTE_WRITE_EN (see dmem_array).
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Aligned and in range: low two bits clear and word index below the depth.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr,
                                   input int unsigned       depth_words);
    return (addr[1:0] == 2'b00) && (32'(addr[ADDR_W-1:2]) < depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-organised storage with one synchronous write port, a
// combinational read of the same address, and asynchronous clear.
// Build option: DMEM_BYTE_WRITE_EN
//   defined   -> only bytes whose be bit is 1 are written
//   undefined -> be has no effect, every write updates the full word
// Ports:
//   clk, rst   : clock (rising edge) and asynchronous active-high clear
//   we         : write strobe for this cycle
//   addr       : word address
//   wdata, be  : write data and byte enables
//   rdata_c    : combinational read data at addr
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [WORD_W-1:0]             wdata,
  input  logic [BE_W-1:0]               be,
  output logic [WORD_W-1:0]             rdata_c
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  logic [BE_W-1:0]   wmask_c;

  // Effective byte mask; without byte writes the mask is forced to all ones.
`ifdef DMEM_BYTE_WRITE_EN
  assign wmask_c = be;
`else
  assign wmask_c = be | {BE_W{1'b1}};
`endif

  // Storage update with per-byte masking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (wmask_c[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for a MIPS load/store unit.
// A request is latched on acceptance; the array is accessed on the edge that
// enters RESP, LATENCY-1 edges later, and the response is held until taken.
// Build option: DMEM_BYTE_WRITE_EN (byte-masked stores, handled in dmem_array).
// Ports:
//   CLK, RESET            : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake
//   req_write             : 1 = store, 0 = load
//   req_addr, req_wdata   : byte address and store data
//   req_be                : store byte enables
//   resp_valid/resp_ready : response handshake
//   resp_rdata            : load data (0 for stores and errors)
//   resp_error            : misaligned or out-of-range access
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_error
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               ready_nx, valid_nx, err_nx;
  logic [WORD_W-1:0]  rdata_nx;

  logic               lat_write;
  logic [ADDR_W-1:0]  lat_addr;
  logic [WORD_W-1:0]  lat_wdata;
  logic [BE_W-1:0]    lat_be;

  logic               accept_c, enter_resp_c;
  logic               acc_write_c, acc_err_c, mem_we_c;
  logic [ADDR_W-1:0]  acc_addr_c;
  logic [WORD_W-1:0]  acc_wdata_c, mem_rdata_c;
  logic [BE_W-1:0]    acc_be_c;

  assign accept_c = (state == IDLE) && req_valid && req_ready;

  // With LATENCY=1 the access happens on the acceptance edge, so use live inputs.
  assign acc_write_c = (state == IDLE) ? req_write : lat_write;
  assign acc_addr_c  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_wdata_c = (state == IDLE) ? req_wdata : lat_wdata;
  assign acc_be_c    = (state == IDLE) ? req_be    : lat_be;
  assign acc_err_c   = !addr_ok(acc_addr_c, DEPTH_WORDS);

  assign mem_we_c = enter_resp_c && acc_write_c && !acc_err_c;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (CLK),
    .rst     (RESET),
    .we      (mem_we_c),
    .addr    (acc_addr_c[AW+1:2]),
    .wdata   (acc_wdata_c),
    .be      (acc_be_c),
    .rdata_c (mem_rdata_c)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    ready_nx     = req_ready;
    valid_nx     = resp_valid;
    rdata_nx     = resp_rdata;
    err_nx       = resp_error;
    enter_resp_c = 1'b0;

    case (state)
      IDLE: begin
        if (accept_c) begin
          if (LATENCY == 1) begin
            enter_resp_c = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_W'(LATENCY - 1);
            ready_nx = 1'b0;
          end
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          enter_resp_c = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nx = IDLE;
          ready_nx = 1'b1;
          valid_nx = 1'b0;
          rdata_nx = '0;
          err_nx   = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
        valid_nx = 1'b0;
        rdata_nx = '0;
        err_nx   = 1'b0;
      end
    endcase

    if (enter_resp_c) begin
      state_nx = RESP;
      cnt_nx   = '0;
      ready_nx = 1'b0;
      valid_nx = 1'b1;
      err_nx   = acc_err_c;
      rdata_nx = (acc_err_c || acc_write_c) ? '0 : mem_rdata_c;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      req_ready  <= ready_nx;
      resp_valid <= valid_nx;
      resp_rdata <= rdata_nx;
      resp_error <= err_nx;
    end
  end

  // Request fields captured at acceptance; held through WAIT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (accept_c) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 4) each driven by
// directed scenarios followed by random traffic, checked every cycle against
// a transaction-level model (word array + pending-request age).
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int          NI    = 3;

`ifdef DMEM_BYTE_WRITE_EN
  localparam logic [31:0] MERGE_EXP = 32'h11BB33DD;
  localparam logic [31:0] BE0_EXP   = 32'h55667788;
`else
  localparam logic [31:0] MERGE_EXP = 32'hAABBCCDD;
  localparam logic [31:0] BE0_EXP   = 32'h99999999;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_error;
    logic [31:0] resp_rdata;
    bit          done = 1'b0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .CLK(clk), .RESET(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    // Reference model: one outstanding request aged in clock edges.
    logic [31:0] mmem [DEPTH];
    bit          m_pend = 1'b0;
    int          m_age = 0;
    bit          m_err = 1'b0, m_wr = 1'b0;
    logic [31:0] m_rdata = '0, m_addr = '0, m_wdata = '0;
    logic [3:0]  m_be = '0;

    function automatic string nm(input string s);
      return $sformatf("L%0d %s", LAT, s);
    endfunction

    function automatic void resolve();
      int unsigned w;
      w = m_addr >> 2;
      m_err   = (m_addr[1:0] != 2'b00) || (w >= DEPTH);
      m_rdata = '0;
      if (!m_err) begin
        if (m_wr) begin
`ifdef DMEM_BYTE_WRITE_EN
          for (int b = 0; b < 4; b++)
            if (m_be[b]) mmem[w][8*b +: 8] = m_wdata[8*b +: 8];
`else
          mmem[w] = m_wdata;
`endif
        end else begin
          m_rdata = mmem[w];
        end
      end
    endfunction

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_pend = 1'b0; m_age = 0; m_rdata = '0; m_err = 1'b0;
        foreach (mmem[i]) mmem[i] = '0;
      end else if (m_pend) begin
        if (m_age >= int'(LAT)) begin
          if (resp_ready) m_pend = 1'b0;
        end else begin
          m_age++;
          if (m_age == int'(LAT)) resolve();
        end
      end else if (req_valid) begin
        m_wr = req_write; m_addr = req_addr; m_wdata = req_wdata; m_be = req_be;
        m_pend = 1'b1; m_age = 1;
        if (m_age == int'(LAT)) resolve();
      end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
      bit v;
      v = m_pend && (m_age >= int'(LAT));
      chk(nm("req_ready"),  32'(req_ready),  32'(!m_pend));
      chk(nm("resp_valid"), 32'(resp_valid), 32'(v));
      chk(nm("resp_rdata"), resp_rdata,      v ? m_rdata : 32'h0);
      chk(nm("resp_error"), 32'(resp_error), 32'(v && m_err));
    end

    task automatic do_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input bit rr,
                          output logic [31:0] rd, output logic er, output int lat);
      int n;
      n = 0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
      resp_ready = rr;
      while (!req_ready && n < 50) begin tick(); n++; end
      chk(nm("accept in time"), 32'(n < 50), 32'd1);
      tick();
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 60) begin tick(); lat++; end
      rd = resp_rdata;
      er = resp_error;
    endtask

    initial begin
      logic [31:0] rd, a;
      logic        er;
      int          lat, cnt, r;

      rst = 1'b1;
      tick(); tick();
      chk(nm("reset req_ready"), 32'(req_ready), 32'd1);
      chk(nm("reset resp_valid"), 32'(resp_valid), 32'd0);
      chk(nm("reset resp_rdata"), resp_rdata, 32'h0);
      rst = 1'b0;
      tick();

      // Store then load back.
      do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, rd, er, lat);
      chk(nm("store latency"), 32'(lat), 32'(LAT));
      chk(nm("store rdata"), rd, 32'h0);
      tick();
      do_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, lat);
      chk(nm("load latency"), 32'(lat), 32'(LAT));
      chk(nm("load 0x10"), rd, 32'hDEADBEEF);
      chk(nm("load 0x10 err"), 32'(er), 32'd0);
      tick();

      // Error cases leave the array untouched.
      do_txn(1'b0, 32'h13, 32'h0, 4'h0, 1'b1, rd, er, lat);
      chk(nm("misaligned err"), 32'(er), 32'd1);
      chk(nm("misaligned rdata"), rd, 32'h0);
      tick();
      do_txn(1'b0, 32'h400, 32'h0, 4'h0, 1'b1, rd, er, lat);
      chk(nm("out of range err"), 32'(er), 32'd1);
      tick();
      do_txn(1'b1, 32'h11, 32'h0, 4'hF, 1'b1, rd, er, lat);
      chk(nm("misaligned store err"), 32'(er), 32'd1);
      tick();
      do_txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, lat);
      chk(nm("word 4 unchanged"), rd, 32'hDEADBEEF);
      tick();

      // Byte-enable merge and be=0 store.
      do_txn(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1, rd, er, lat); tick();
      do_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, rd, er, lat); tick();
      do_txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, rd, er, lat);
      chk(nm("be merge"), rd, MERGE_EXP);
      tick();
      do_txn(1'b1, 32'h24, 32'h55667788, 4'hF, 1'b1, rd, er, lat); tick();
      do_txn(1'b1, 32'h24, 32'h99999999, 4'h0, 1'b1, rd, er, lat);
      chk(nm("be0 store err"), 32'(er), 32'd0);
      tick();
      do_txn(1'b0, 32'h24, 32'h0, 4'h0, 1'b1, rd, er, lat);
      chk(nm("be0 result"), rd, BE0_EXP);
      tick();

      // Back-pressure on the response.
      do_txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er, lat);
      chk(nm("stall first data"), rd, MERGE_EXP);
      for (int i = 0; i < 5; i++) begin
        tick();
        chk(nm("stall req_ready"), 32'(req_ready), 32'd0);
        chk(nm("stall resp_valid"), 32'(resp_valid), 32'd1);
        chk(nm("stall resp_rdata"), resp_rdata, rd);
      end
      resp_ready = 1'b1;
      tick();
      chk(nm("release resp_valid"), 32'(resp_valid), 32'd0);
      chk(nm("release req_ready"), 32'(req_ready), 32'd1);

      // Reset while a store is in flight.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8;
      req_wdata = 32'h12345678; req_be = 4'hF;
      tick();
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk(nm("mid reset req_ready"), 32'(req_ready), 32'd1);
      chk(nm("mid reset resp_valid"), 32'(resp_valid), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      do_txn(1'b0, 32'h8, 32'h0, 4'h0, 1'b1, rd, er, lat);
      chk(nm("abandoned store"), rd, 32'h0);
      tick();

      // Back-to-back loads with req_valid held: one response per LAT+1 cycles.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; resp_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 4 * (int'(LAT) + 1); i++) begin
        tick();
        if (resp_valid) cnt++;
      end
      chk(nm("b2b response count"), 32'(cnt), 32'd4);
      req_valid = 1'b0;
      repeat (LAT + 3) tick();

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
        rst       = ($urandom % 250) == 0;
        req_valid = $urandom % 2;
        req_write = $urandom % 2;
        r = int'($urandom % 10);
        if (r < 7)      a = 32'($urandom % 12) << 2;
        else if (r < 9) a = (32'($urandom % 12) << 2) | 32'($urandom_range(1, 3));
        else            a = $urandom | 32'h400;
        req_addr   = a;
        req_wdata  = $urandom;
        req_be     = 4'($urandom);
        resp_ready = ($urandom % 3) != 0;
        tick();
      end
      rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      repeat (LAT + 3) tick();
      done = 1'b1;
    end
  end

  initial begin
    int c;
    c = 0;
    while (!(inst[0].done && inst[1].done && inst[2].done) && c < 60000) begin
      @(posedge clk);
      c++;
    end
    if (c >= 60000) begin
      total++;
      bad++;
      $display("FAIL run timeout: got %0d cycles want completion", c);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder that serves load/store requests from a pipelined or multi-cycle MIPS core over a valid/ready request and response handshake. It replaces the zero-latency combinational data memory with a word-organised storage array. Access latency is configurable, and accesses that are misaligned or out of range are flagged as errors. The core's load/store unit is the initiator; this block is the responder at the other end of that interface.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of two, at least 4.
LATENCY, 2, cycles from request acceptance to resp_valid assertion; must be at least 1.

Ports:
CLK  in  1  clock, rising edge.
RESET  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  responder can accept a request.
req_write  in  1  1 = store, 0 = load.
req_addr  in  32  byte address.
req_wdata  in  32  store data.
req_be  in  4  byte enables for stores; bit i selects byte i, bits [8i+7:8i].
resp_valid  out  1  response present.
resp_ready  in  1  initiator accepts the response.
resp_rdata  out  32  load data; 0 for stores and for errors.
resp_error  out  1  misaligned or out-of-range access.

Behaviour:
- Reset (asynchronous, while RESET=1):
  - state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_error=0.
  - Latency counter is 0; all memory words are 0.
- Acceptance: a request is accepted on the rising edge where req_valid=1 and req_ready=1. At that edge, req_write, req_addr, req_wdata and req_be are latched. The inputs are ignored afterwards.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On acceptance, go to WAIT with counter=LATENCY-1. If LATENCY=1, go directly to RESP.
  - WAIT: req_ready=0. The counter decrements each cycle. When the counter is 1, the next edge enters RESP.
  - RESP: resp_valid=1, req_ready=0. resp_rdata and resp_error hold stable until the handshake. When resp_ready=1, the next edge returns to IDLE and clears resp_valid, resp_rdata and resp_error.
- Latency: resp_valid rises exactly LATENCY cycles after the acceptance edge.
- Throughput: at most one transaction per LATENCY+1 cycles. A request cannot be accepted in the same cycle as a response handshake.
- Error check: error = (addr[1:0] != 0) OR (addr[31:2] >= DEPTH_WORDS).
  - On error: no array access, resp_error=1, resp_rdata=0.
- Access timing: the array access happens on the edge entering RESP.
  - Loads capture mem[addr[31:2]] into resp_rdata.
  - Stores commit req_wdata under the byte-enable rule and set resp_rdata=0.
- Stores with req_be=4'b0000 write nothing and still complete with resp_error=0.
- Read-after-write: a load accepted after a store's response handshake observes the stored data.
- Reset during WAIT or RESP: the transaction is abandoned, a pending store is not committed, and the block returns to IDLE.
- resp_ready asserted outside RESP is ignored. req_valid asserted outside IDLE is not accepted; the initiator must hold it.

Optional Feature:
DMEM_BYTE_WRITE_EN
- Defined: stores update only the bytes whose req_be bit is 1; other bytes keep their old value.
- Undefined: req_be is ignored, every non-error store writes all 32 bits, and the be=0 case writes the full word.
- The port list is identical in both builds.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, WAIT, RESP}.
  - Localparam WORD_W=32 and BE_W=4.
  - An in_range/aligned checking function.
- Sub-module dmem_array holds the storage: one synchronous write/read port with byte enables and asynchronous clear on RESET. The DMEM_BYTE_WRITE_EN masking is implemented inside it. The FSM, latency counter, error logic and handshake stay in dmem_responder.

Test Plan:
1. Reset, then store addr=0x10, wdata=0xDEADBEEF, be=4'hF, followed by a load from 0x10 (LATENCY=2) -> each resp_valid rises 2 cycles after acceptance; the load returns 0xDEADBEEF with resp_error=0.
2. Load from addr=0x13, then load from addr=0x400 (DEPTH_WORDS=256) -> both return resp_error=1 and resp_rdata=0; word 4 is unchanged on re-read.
3. With DMEM_BYTE_WRITE_EN: write 0x11223344 to 0x20, then store 0xAABBCCDD with be=4'b0101, then load -> 0x11BB33DD. Without the macro: 0xAABBCCDD.
4. Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_error stay stable and req_ready stays 0; raising resp_ready returns to IDLE on the next edge.
5. Accept a store to 0x8 with 0x12345678, then assert RESET mid-WAIT (LATENCY=4) -> outputs go to reset values immediately; a subsequent load from 0x8 returns 0.
6. With LATENCY=1, issue back-to-back loads with req_valid held high and resp_ready=1 -> one response every 2 cycles, with resp_valid 1 cycle after each acceptance.
